// File: rtl/instr_encoder_if.sv
// Request stream, instruction-memory write port and session control/status
// of the instruction encoder, bundled as one interface.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              mem_ready;
    logic [ADDR_W:0]   count;
    logic              err;
    logic              full;
    logic              done;

    // Encoder side
    modport slave (
        input  start, finish, in_valid, op_sel, rs, rt, rd, imm, target, mem_ready,
        output in_ready, wr_en, wr_addr, wr_data, count, err, full, done
    );

    // Program source / memory side
    modport master (
        output start, finish, in_valid, op_sel, rs, rt, rd, imm, target, mem_ready,
        input  in_ready, wr_en, wr_addr, wr_data, count, err, full, done
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into 32-bit MIPS words and writes them
// sequentially into instruction memory through a registered, back-pressured
// write port. Sessions run IDLE -> RUN -> DRAIN -> DONE.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

    state_t            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   acc_q, acc_d;
    logic              err_q, err_d;
    logic              full_q, full_d;
    logic              done_q, done_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              in_ready_w;
    logic              accept;
    logic              acc_legal;
    logic              acc_illegal;
    logic              wr_done;

    // Instruction encoding of the request currently presented
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (bus.op_sel)
            4'd0:    enc_word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'h20};
            4'd1:    enc_word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'h22};
            4'd2:    enc_word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'h24};
            4'd3:    enc_word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'h25};
            4'd4:    enc_word = {6'h00, bus.rs, bus.rt, bus.rd, 5'd0, 6'h2A};
            4'd5:    enc_word = {6'h23, bus.rs, bus.rt, bus.imm};
            4'd6:    enc_word = {6'h2B, bus.rs, bus.rt, bus.imm};
            4'd7:    enc_word = {6'h04, bus.rs, bus.rt, bus.imm};
            4'd8:    enc_word = {6'h05, bus.rs, bus.rt, bus.imm};
            4'd9:    enc_word = {6'h02, bus.target};
            4'd10:   enc_word = {6'h09, bus.rs, bus.rt, bus.imm};
            default: enc_legal = 1'b0;
        endcase
    end

    // finish has priority over a request presented in the same cycle
    assign in_ready_w  = (state_q == RUN) && !full_q && (!wr_en_q || bus.mem_ready)
                         && !bus.finish;
    assign accept      = bus.in_valid && in_ready_w;
    assign acc_legal   = accept && enc_legal;
    assign acc_illegal = accept && !enc_legal;
    assign wr_done     = wr_en_q && bus.mem_ready;

    // Next-state, write-port and session bookkeeping
    always_comb begin
        state_d     = state_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        next_addr_d = next_addr_q;
        wr_data_d   = wr_data_q;
        count_d     = count_q;
        acc_d       = acc_q;
        err_d       = err_q;
        full_d      = full_q;

        if (wr_done) begin
            count_d = count_q + 1'b1;
            wr_en_d = 1'b0;
        end
        // a new accept in the handshake cycle keeps wr_en high
        if (acc_legal) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = next_addr_q;
            wr_data_d   = enc_word;
            next_addr_d = next_addr_q + 1'b1;
            acc_d       = acc_q + 1'b1;
            if ((acc_q + 1'b1) == MAX_CNT) begin
                full_d = 1'b1;
            end
        end
        if (acc_illegal) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    count_d     = '0;
                    acc_d       = '0;
                    err_d       = 1'b0;
                    full_d      = 1'b0;
                    next_addr_d = BASE;
                end
            end
            RUN: begin
                if (bus.finish || full_d) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!wr_en_q || bus.mem_ready) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= BASE;
            next_addr_q <= BASE;
            wr_data_q   <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            next_addr_q <= next_addr_d;
            wr_data_q   <= wr_data_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            full_q      <= full_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready = in_ready_w;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.count    = count_q;
    assign bus.err      = err_q;
    assign bus.full     = full_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a table of single-instruction sessions
// plus hand-written sequences for streaming, stalls, illegal ops, full and
// mid-write reset. DUT built with ADDR_W=2, BASE_ADDR=1, MAX_WORDS=4 so the
// address wraps and the full limit is reachable.
module tb_instr_encoder;
    localparam int unsigned AW   = 2;
    localparam int unsigned BASE = 1;
    localparam int unsigned MAXW = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(
        .ADDR_W   (AW),
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        wen;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[12];
    vec_t b2b[5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.op_sel = v.op;
        bus.rs     = v.rs;
        bus.rt     = v.rt;
        bus.rd     = v.rd;
        bus.imm    = v.imm;
        bus.target = v.tgt;
    endtask

    task automatic start_session();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_count", 32'(bus.count), 0);
        chk("start_err", 32'(bus.err), 0);
        chk("start_done", 32'(bus.done), 0);
        chk("start_full", 32'(bus.full), 0);
    endtask

    task automatic finish_session();
        bus.in_valid = 1'b0;
        bus.finish   = 1'b1;
        tick();
        bus.finish = 1'b0;
        tick();
        chk("session_done", 32'(bus.done), 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            op     rs     rt     rd     imm       tgt           wen   data
        vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       1'b1, 32'h00221820};
        vecs[1]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h0000, 26'h0,       1'b1, 32'h00853022};
        vecs[2]  = '{4'd2,  5'd7,  5'd8,  5'd9,  16'h1234, 26'h0,       1'b1, 32'h00E84824};
        vecs[3]  = '{4'd3,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h03FFF825};
        vecs[4]  = '{4'd4,  5'd10, 5'd11, 5'd12, 16'h0000, 26'h0,       1'b1, 32'h014B602A};
        vecs[5]  = '{4'd5,  5'd29, 5'd8,  5'd0,  16'h0004, 26'h0,       1'b1, 32'h8FA80004};
        vecs[6]  = '{4'd6,  5'd29, 5'd31, 5'd17, 16'hFFF8, 26'h0,       1'b1, 32'hAFBFFFF8};
        vecs[7]  = '{4'd7,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       1'b1, 32'h1022FFFF};
        vecs[8]  = '{4'd8,  5'd3,  5'd0,  5'd5,  16'h0010, 26'h0,       1'b1, 32'h14600010};
        vecs[9]  = '{4'd9,  5'd31, 5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF};
        vecs[10] = '{4'd10, 5'd0,  5'd5,  5'd0,  16'h0007, 26'h0,       1'b1, 32'h24050007};
        vecs[11] = '{4'd12, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       1'b0, 32'h00000000};

        b2b[0] = '{4'd5,  5'd29, 5'd8, 5'd0, 16'h0004, 26'h0,      1'b1, 32'h8FA80004};
        b2b[1] = '{4'd7,  5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0,      1'b1, 32'h1022FFFF};
        b2b[2] = '{4'd9,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h100000, 1'b1, 32'h08100000};
        b2b[3] = '{4'd10, 5'd0,  5'd5, 5'd0, 16'h0007, 26'h0,      1'b1, 32'h24050007};
        b2b[4] = '{4'd0,  5'd1,  5'd2, 5'd3, 16'h0000, 26'h0,      1'b1, 32'h00221820};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.finish    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b0;
        drive(vecs[0]);
        tick();
        tick();
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), BASE);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        chk("idle_in_ready", 32'(bus.in_ready), 0);
        chk("idle_no_write", 32'(bus.wr_en), 0);
        bus.in_valid = 1'b0;

        // one request per session, each written at BASE
        for (int i = 0; i < 12; i++) begin
            start_session();
            drive(vecs[i]);
            bus.in_valid  = 1'b1;
            bus.mem_ready = 1'b1;
            #1;
            chk("vec_in_ready", 32'(bus.in_ready), 1);
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_wr_en", i), 32'(bus.wr_en), 32'(vecs[i].wen));
            chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'(!vecs[i].wen));
            if (vecs[i].wen) begin
                chk($sformatf("vec%0d_data", i), bus.wr_data, vecs[i].data);
                chk($sformatf("vec%0d_addr", i), 32'(bus.wr_addr), BASE);
            end
            finish_session();
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].wen));
        end

        // back-to-back stream reaching full; fifth request refused; address wraps
        start_session();
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(b2b[k]);
            bus.in_valid = 1'b1;
            #1;
            chk($sformatf("b2b%0d_in_ready", k), 32'(bus.in_ready), 1);
            tick();
            chk($sformatf("b2b%0d_wr_en", k), 32'(bus.wr_en), 1);
            chk($sformatf("b2b%0d_addr", k), 32'(bus.wr_addr), (BASE + k) % (1 << AW));
            chk($sformatf("b2b%0d_data", k), bus.wr_data, b2b[k].data);
            chk($sformatf("b2b%0d_count", k), 32'(bus.count), k);
        end
        drive(b2b[4]);
        #1;
        chk("full_set", 32'(bus.full), 1);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        tick();
        bus.in_valid = 1'b0;
        chk("full_no_fifth", 32'(bus.wr_en), 0);
        chk("full_count", 32'(bus.count), 4);
        chk("full_done", 32'(bus.done), 1);
        tick();
        chk("done_level", 32'(bus.done), 1);
        chk("done_count_hold", 32'(bus.count), 4);

        // SW stalled by mem_ready=0 for three cycles
        start_session();
        drive(vecs[6]);
        bus.in_valid  = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_wr_en", 32'(bus.wr_en), 1);
            chk("stall_addr", 32'(bus.wr_addr), BASE);
            chk("stall_data", bus.wr_data, 32'hAFBFFFF8);
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            chk("stall_count", 32'(bus.count), 0);
            tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        chk("release_count", 32'(bus.count), 1);
        chk("release_wr_en", 32'(bus.wr_en), 0);
        tick();
        chk("release_single", 32'(bus.count), 1);
        finish_session();

        // illegal op between two ADDs, then finish racing a request
        start_session();
        bus.mem_ready = 1'b1;
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        tick();
        chk("ill_add1_addr", 32'(bus.wr_addr), BASE);
        chk("ill_add1_data", bus.wr_data, 32'h00221820);
        bus.op_sel = 4'd12;
        #1;
        chk("ill_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk("ill_err", 32'(bus.err), 1);
        chk("ill_no_write", 32'(bus.wr_en), 0);
        chk("ill_count", 32'(bus.count), 1);
        bus.op_sel = 4'd0;
        bus.rs     = 5'd2;
        bus.rt     = 5'd3;
        bus.rd     = 5'd4;
        tick();
        chk("ill_add2_wr_en", 32'(bus.wr_en), 1);
        chk("ill_add2_addr", 32'(bus.wr_addr), (BASE + 1) % (1 << AW));
        chk("ill_add2_data", bus.wr_data, 32'h00432020);
        bus.finish = 1'b1;
        #1;
        chk("finish_wins", 32'(bus.in_ready), 0);
        tick();
        bus.finish   = 1'b0;
        bus.in_valid = 1'b0;
        chk("finish_no_accept", 32'(bus.wr_en), 0);
        chk("finish_count", 32'(bus.count), 2);
        tick();
        chk("ill_done", 32'(bus.done), 1);
        chk("ill_err_sticky", 32'(bus.err), 1);
        chk("ill_not_full", 32'(bus.full), 0);

        // reset while a write is stalled, then restart at BASE
        start_session();
        drive(vecs[1]);
        bus.in_valid  = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("pre_rst_wr_en", 32'(bus.wr_en), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_wr_en", 32'(bus.wr_en), 0);
        chk("mid_rst_addr", 32'(bus.wr_addr), BASE);
        chk("mid_rst_data", bus.wr_data, 0);
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        start_session();
        drive(vecs[4]);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("restart_addr", 32'(bus.wr_addr), BASE);
        chk("restart_data", bus.wr_data, 32'h014B602A);
        finish_session();
        chk("restart_count", 32'(bus.count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the pipeline's opcode decoder. Accepts symbolic instruction requests (operation class plus register and immediate fields) over a valid/ready stream and encodes them into 32-bit MIPS words. Writes the words sequentially into instruction memory through a registered write port with back-pressure. Used by the bench and boot path to load programs before the pipeline runs.

Parameters:
ADDR_W, 8, instruction-memory word-address width
BASE_ADDR, 0, first word address written after start
MAX_WORDS, 256, words accepted before full; must be ≤ 2^ADDR_W

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  pulse; begin a load session at BASE_ADDR
finish  input  1  pulse; end the session after pending write drains
in_valid  input  1  request valid
in_ready  output  1  encoder accepts request this cycle
op_sel  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J, 10 ADDIU, 11-15 illegal
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register (R-type only)
imm  input  16  immediate / branch offset (I-type)
target  input  26  jump target (J)
wr_en  output  1  instruction-memory write valid
wr_addr  output  ADDR_W  word address
wr_data  output  32  encoded instruction
mem_ready  input  1  memory accepts the write this cycle
count  output  ADDR_W+1  words written this session
err  output  1  sticky; an illegal op_sel was accepted
full  output  1  MAX_WORDS accepted
done  output  1  session complete; level until next start

Behaviour:
- Reset (rst_n low at the edge): state IDLE; wr_en=0, wr_addr=BASE_ADDR, wr_data=0, count=0, err=0, full=0, done=0, in_ready=0. Reset mid-session aborts it. A pending write is dropped.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start. This clears count, err, full and done, and sets the next address to BASE_ADDR.
  - RUN→DRAIN on finish, or when the accept count reaches MAX_WORDS.
  - DRAIN→DONE once wr_en=0, or once wr_en=1 with mem_ready=1.
  - DONE→RUN on start.
  - start is ignored in RUN and DRAIN. finish is ignored outside RUN.
- Handshake:
  - in_ready = (state==RUN) && !full && (!wr_en || mem_ready).
  - A transfer occurs when in_valid && in_ready.
  - in_ready is forced 0 in the cycle where finish is sampled.
- Latency: an accepted legal request produces wr_en=1 on the next cycle, with wr_data and wr_addr registered.
  - wr_en, wr_addr and wr_data hold stable while mem_ready=0.
  - wr_en drops the cycle after the mem_ready handshake unless a new request was accepted the same cycle. Back-to-back accepts give 1 word/cycle.
- Addressing: wr_addr increments by 1 per legal accept and wraps modulo 2^ADDR_W.
- count: increments on each completed write (wr_en && mem_ready).
- full: set when legal accepts reach MAX_WORDS.
- Encoding: fields are placed as opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6]=0, funct[5:0], imm[15:0], target[25:0].
  - R-type: opcode 0, with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type: LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, ADDIU 0x09, using rs, rt and imm. Unused fields are ignored.
  - J-type: J 0x02 with target.
- Illegal op_sel (11-15): the request is accepted (handshake completes), nothing is written, the address does not advance, and err is set (sticky).
- Simultaneous finish and in_valid in RUN: finish wins and the request is not accepted.

Test Plan:
- Reset, start, send ADD rs=1 rt=2 rd=3 → next cycle wr_en=1, wr_addr=0, wr_data=0x00221820. With mem_ready=1, count=1.
- Back-to-back LW rs=29 rt=8 imm=4; BEQ rs=1 rt=2 imm=0xFFFF; J target=0x100000; ADDIU rs=0 rt=5 imm=7, mem_ready=1 → data 0x8FA80004, 0x1022FFFF, 0x08100000, 0x24050007 at addr 0..3. in_ready stays 1.
- mem_ready held 0 for 3 cycles during an SW → wr_en, addr and data are stable and in_ready=0. Release mem_ready → exactly one write occurs and count increments by 1.
- op_sel=12 mid-stream between two ADDs → err=1, no write for it, and the second ADD lands at the next consecutive address.
- MAX_WORDS=4: send 5 requests → 4 written, full=1, 5th not accepted, done=1 after the last write drains.
- Assert rst_n=0 while wr_en=1 and mem_ready=0 → next cycle all outputs are at reset values and state is IDLE. A subsequent start restarts at BASE_ADDR.
